// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared sizing constants, state encoding and address helpers for the
// instruction-memory fetch sequencer.
package imem_fetch_pkg;

    localparam int WL     = 32;
    localparam int DEPTH  = WL * 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    // Word indices must always land inside the RAM, so the upper bits are dropped.
    function automatic logic [WL-1:0] wrap_addr(input logic [WL-1:0] addr);
        return addr & WL'(DEPTH - 1);
    endfunction

    function automatic logic out_of_range(input logic [WL-1:0] addr);
        return addr >= WL'(DEPTH);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of loader stream, core control, RAM port and status signals
// around the fetch sequencer.
interface imem_fetch_ctrl_if;
    import imem_fetch_pkg::*;

    logic          ld_valid;
    logic          ld_ready;
    logic [WL-1:0] ld_data;
    logic          ld_last;

    logic          run_start;
    logic          stall;
    logic          redirect_en;
    logic [WL-1:0] redirect_pc;
    logic          halt_inst;

    logic [WL-1:0] imem_addr;
    logic          imem_we;
    logic [WL-1:0] imem_wd;

    logic [WL-1:0] pc;
    logic          pc_valid;
    logic [1:0]    state;
    logic          load_done;
    logic          err_ovf;
    logic          err_addr;

    // The master is the loader/core side; the slave is the sequencer itself.
    modport master (
        output ld_valid, ld_data, ld_last,
        output run_start, stall, redirect_en, redirect_pc, halt_inst,
        input  ld_ready, imem_addr, imem_we, imem_wd,
        input  pc, pc_valid, state, load_done, err_ovf, err_addr
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        input  run_start, stall, redirect_en, redirect_pc, halt_inst,
        output ld_ready, imem_addr, imem_we, imem_wd,
        output pc, pc_valid, state, load_done, err_ovf, err_addr
    );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// Program-counter owner for the instruction RAM: streams a program in,
// then fetches with stall, redirect and halt control.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    imem_fetch_ctrl_if.slave bus
);

    fetch_state_t      state_q, state_d;
    logic [WL-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              load_done_q, load_done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_addr_q, err_addr_d;

    logic              ld_ready;
    logic              accept;

    // The loader may write whenever the core is not fetching.
    assign ld_ready = (state_q != ST_RUN);
    assign accept   = bus.ld_valid & ld_ready;

    assign bus.ld_ready  = ld_ready;
    assign bus.imem_we   = accept;
    assign bus.imem_wd   = bus.ld_data;
    assign bus.imem_addr = (state_q == ST_RUN) ? pc_q : WL'(wptr_q);

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = (state_q == ST_RUN);
    assign bus.state     = state_q;
    assign bus.load_done = load_done_q;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_addr  = err_addr_q;

    // Next-state logic: a pending load always wins over run_start when idle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wptr_d      = wptr_q;
        load_done_d = 1'b0;
        err_ovf_d   = err_ovf_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (accept) begin
                    if (bus.ld_last) begin
                        state_d     = ST_IDLE;
                        wptr_d      = '0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        wptr_d  = wptr_q + ADDR_W'(1);
                    end
                end else if (bus.run_start) begin
                    pc_d    = '0;
                    state_d = ST_RUN;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    if (bus.ld_last) begin
                        state_d     = ST_IDLE;
                        wptr_d      = '0;
                        load_done_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                        if (wptr_q == ADDR_W'(DEPTH - 1)) begin
                            err_ovf_d = 1'b1;
                        end
                    end
                end
            end

            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.halt_inst) begin
                        state_d = ST_HALT;
                    end else if (bus.redirect_en) begin
                        pc_d = wrap_addr(bus.redirect_pc);
                        if (out_of_range(bus.redirect_pc)) begin
                            err_addr_d = 1'b1;
                        end
                    end else begin
                        pc_d = wrap_addr(pc_q + WL'(1));
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state; the error flags are sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            wptr_q      <= '0;
            load_done_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wptr_q      <= wptr_d;
            load_done_q <= load_done_d;
            err_ovf_q   <= err_ovf_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed plus randomized bench for imem_fetch_ctrl with a behavioural
// RAM and a reference model of load/run behaviour.
module tb_imem_fetch_ctrl;
    import imem_fetch_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [WL-1:0] ram   [DEPTH];
    logic [WL-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_state;
    int            m_pc;
    int            m_wptr;
    bit            m_done;
    bit            m_ovf;
    bit            m_eaddr;
    logic [WL-1:0] last_word;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the sibling instruction RAM.
    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) ram[bus.imem_addr[ADDR_W-1:0]] <= bus.imem_wd;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_wptr  = 0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
        m_eaddr = 1'b0;
    endtask

    task automatic model_update();
        bit acc;
        longint unsigned rp;
        acc    = (bus.ld_valid === 1'b1) && (m_state != M_RUN);
        rp     = bus.redirect_pc;
        m_done = 1'b0;
        if (m_state == M_RUN) begin
            if (bus.stall) begin
            end else if (bus.halt_inst) begin
                m_state = M_HALT;
            end else if (bus.redirect_en) begin
                m_pc = int'(rp % DEPTH);
                if (rp >= DEPTH) m_eaddr = 1'b1;
            end else begin
                m_pc = (m_pc + 1) % DEPTH;
            end
        end else if (acc) begin
            m_mem[m_wptr]   = bus.ld_data;
            m_known[m_wptr] = 1'b1;
            if (bus.ld_last) begin
                m_state = M_IDLE;
                m_wptr  = 0;
                m_done  = 1'b1;
            end else begin
                if (m_state == M_LOAD && m_wptr == DEPTH - 1) m_ovf = 1'b1;
                m_state = M_LOAD;
                m_wptr  = (m_wptr + 1) % DEPTH;
            end
        end else if (bus.run_start && m_state != M_LOAD) begin
            m_pc    = 0;
            m_state = M_RUN;
        end
    endtask

    task automatic check_all();
        bit exp_ready;
        exp_ready = (m_state != M_RUN);
        check_output("state", 32'(bus.state), 32'(m_state));
        check_output("pc", bus.pc, 32'(m_pc));
        check_output("pc_valid", 32'(bus.pc_valid), 32'(m_state == M_RUN));
        check_output("ld_ready", 32'(bus.ld_ready), 32'(exp_ready));
        check_output("imem_we", 32'(bus.imem_we), 32'(bus.ld_valid & exp_ready));
        check_output("imem_addr", bus.imem_addr, exp_ready ? 32'(m_wptr) : 32'(m_pc));
        check_output("imem_wd", bus.imem_wd, bus.ld_data);
        check_output("load_done", 32'(bus.load_done), 32'(m_done));
        check_output("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
        check_output("err_addr", 32'(bus.err_addr), 32'(m_eaddr));
        if (m_state == M_RUN && m_known[m_pc]) check_output("fetch_word", ram[m_pc], m_mem[m_pc]);
    endtask

    // Inputs change just after the falling edge; outputs are checked before the rising edge.
    task automatic apply_stimulus(input bit v, input bit last, input logic [WL-1:0] d,
                                  input bit run, input bit st, input bit halt,
                                  input bit ren, input logic [WL-1:0] rpc);
        bus.ld_valid    = v;
        bus.ld_last     = last;
        bus.ld_data     = d;
        bus.run_start   = run;
        bus.stall       = st;
        bus.halt_inst   = halt;
        bus.redirect_en = ren;
        bus.redirect_pc = rpc;
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        bus.ld_valid    = 1'b0;
        bus.ld_last     = 1'b0;
        bus.ld_data     = '0;
        bus.run_start   = 1'b0;
        bus.stall       = 1'b0;
        bus.halt_inst   = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();

        @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] four-word program load");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, i == 3, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();
        idle();
        check_output("load4_state", 32'(bus.state), 32'(M_IDLE));

        $display("[TB] run with stall and redirect");
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_output("first_run_pc", bus.pc, 32'd0);
        idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_output("stall_hold", bus.pc, 32'd1);
        idle();
        idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
        check_output("redirect_target", bus.pc, 32'h10);
        idle();

        $display("[TB] halt beats redirect");
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20);
        check_output("halt_state", 32'(bus.state), 32'(M_HALT));
        check_output("halt_pc", bus.pc, 32'h11);
        check_output("halt_pc_valid", 32'(bus.pc_valid), 32'd0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_output("restart_pc", bus.pc, 32'd0);
        idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        $display("[TB] overflowing load of 257 words");
        for (int i = 0; i < DEPTH + 1; i++) begin
            last_word = $urandom;
            apply_stimulus(1'b1, 1'b0, last_word, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_output("ovf_flag", 32'(bus.err_ovf), 32'd1);
        check_output("ovf_wrap_write", ram[0], last_word);
        apply_stimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();
        check_output("ovf_sticky", 32'(bus.err_ovf), 32'd1);

        $display("[TB] out-of-range redirect");
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h105);
        check_output("redirect_wrap_pc", bus.pc, 32'h05);
        check_output("redirect_err", 32'(bus.err_addr), 32'd1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        $display("[TB] async reset mid-load");
        apply_stimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        bus.ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_output("rst_wptr_addr", bus.imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, i == 2, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(($urandom % 3) == 0, ($urandom % 8) == 0, $urandom,
                           ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 16) == 0,
                           ($urandom % 6) == 0,
                           (($urandom % 2) == 0) ? 32'($urandom_range(0, DEPTH - 1)) : 32'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
